// File: rtl/ub_csel_sub_seq_if.sv
// Handshake bus for the sequential carry-select subtractor: operand side and result side.
interface ub_csel_sub_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, diff, borrow
    );
endinterface

// File: rtl/ub_csel_sub_seq.sv
// Multi-cycle unsigned subtractor D = X + ~Y + 1, one carry-select block per clock.
// Optional macro UBCSE_SUB_SAT_EN: clamp diff to 0 when the result borrows.
module ub_csel_sub_seq #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] BLK_END_MASK = WIDTH'(8'hCB)
) (
    input  logic               clk,
    input  logic               rst,
    ub_csel_sub_seq_if.slave   bus
);
    localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic             carry_q, carry_nxt;
    logic [PTR_W-1:0] ptr_q, ptr_nxt;
    logic [WIDTH-1:0] diff_q, diff_nxt;
    logic             borrow_q, borrow_nxt;
    logic             out_valid_q, out_valid_nxt;

    logic [WIDTH-1:0] blk_mask, sum0, sum1, blk_sum;
    logic             found, c0, c1, blk_cout;
    int unsigned      blk_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            ptr_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            a_q         <= a_nxt;
            b_q         <= b_nxt;
            carry_q     <= carry_nxt;
            ptr_q       <= ptr_nxt;
            diff_q      <= diff_nxt;
            borrow_q    <= borrow_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    // Current block [ptr .. blk_end]: both carry-in ripple chains, then select.
    always_comb begin
        blk_end  = WIDTH - 1;
        found    = 1'b0;
        blk_mask = '0;
        sum0     = '0;
        sum1     = '0;
        c0       = 1'b0;
        c1       = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && i >= 32'(ptr_q) && BLK_END_MASK[i]) begin
                blk_end = i;
                found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i >= 32'(ptr_q) && i <= blk_end) begin
                blk_mask[i] = 1'b1;
                sum0[i]     = a_q[i] ^ b_q[i] ^ c0;
                sum1[i]     = a_q[i] ^ b_q[i] ^ c1;
                c0          = (a_q[i] & b_q[i]) | (c0 & (a_q[i] ^ b_q[i]));
                c1          = (a_q[i] & b_q[i]) | (c1 & (a_q[i] ^ b_q[i]));
            end
        end
        blk_sum  = carry_q ? sum1 : sum0;
        blk_cout = carry_q ? c1 : c0;
    end

    always_comb begin
        state_nxt     = state_q;
        a_nxt         = a_q;
        b_nxt         = b_q;
        carry_nxt     = carry_q;
        ptr_nxt       = ptr_q;
        diff_nxt      = diff_q;
        borrow_nxt    = borrow_q;
        out_valid_nxt = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_nxt     = bus.x;
                    b_nxt     = ~bus.y;
                    carry_nxt = 1'b1;
                    ptr_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                diff_nxt  = (diff_q & ~blk_mask) | (blk_sum & blk_mask);
                carry_nxt = blk_cout;
                ptr_nxt   = PTR_W'(blk_end + 1);
                if (blk_end == WIDTH - 1) begin
                    borrow_nxt    = ~blk_cout;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
`ifdef UBCSE_SUB_SAT_EN
                    if (!blk_cout) diff_nxt = '0;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is a direct decode of the state flop, forced low while reset is held.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_ub_csel_sub_seq.sv
// Randomized self-checking bench for ub_csel_sub_seq against an arithmetic reference model.
module tb_ub_csel_sub_seq;
    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] MASK = 8'hCB;
    localparam int unsigned NBLK = $countones(MASK);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    ub_csel_sub_seq_if #(.WIDTH(WIDTH)) bus ();

    ub_csel_sub_seq #(.WIDTH(WIDTH), .BLK_END_MASK(MASK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
        int unsigned d;
`ifdef UBCSE_SUB_SAT_EN
        if (xv < yv) return '0;
`endif
        d = (32'(xv) + (1 << WIDTH) - 32'(yv)) % (1 << WIDTH);
        return WIDTH'(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: wait for ready, present operands, count latency, hold, release.
    task automatic run_op(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                          input int hold, input bit rand_noise);
        int w;
        int lat;
        logic [WIDTH-1:0] ed;
        logic eb;
        ed = ref_diff(xv, yv);
        eb = (xv < yv);
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        check("ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.x = xv;
        bus.y = yv;
        tick();
        bus.in_valid = 1'b0;
        bus.x = WIDTH'($urandom);
        bus.y = WIDTH'($urandom);
        lat = 0;
        while (lat < 20) begin
            bus.out_ready = rand_noise ? 1'($urandom) : 1'b0;
            tick();
            lat++;
            if (bus.out_valid) break;
        end
        bus.out_ready = 1'b0;
        check("latency", 32'(lat), 32'(NBLK));
        check("diff", 32'(bus.diff), 32'(ed));
        check("borrow", 32'(bus.borrow), 32'(eb));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.x = WIDTH'($urandom);
            bus.y = WIDTH'($urandom);
            tick();
            check("hold_diff", 32'(bus.diff), 32'(ed));
            check("hold_borrow", 32'(bus.borrow), 32'(eb));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x = '0;
        bus.y = '0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_borrow", 32'(bus.borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        run_op(8'd200, 8'd55, 0, 1'b0);
        run_op(8'd55, 8'd200, 0, 1'b0);
        run_op(8'd0, 8'd1, 0, 1'b0);
        run_op(8'hA5, 8'hA5, 0, 1'b0);
        run_op(8'd0, 8'hFF, 0, 1'b0);
        run_op(8'hFF, 8'd0, 10, 1'b0);

        // Abort on the 3rd BUSY cycle: reset must clear a partly written result.
        tick();
        bus.in_valid = 1'b1;
        bus.x = 8'hFF;
        bus.y = 8'h00;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        check("abort_borrow", 32'(bus.borrow), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_abort_in_ready", 32'(bus.in_ready), 32'd1);
        run_op(8'd128, 8'd127, 0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
